qpsk_modulator: RTL and testbench

QPSK_MODULATOR -- requirements
Module: qpsk_modulator

---
 rtl/qpsk_modulator.sv | 110 +++++++++++
 tb/tb_qpsk_modulator.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_modulator.sv
// Serial-to-QPSK modulator: pairs incoming bits into symbols, queues them in a
// 2-entry FIFO and holds each symbol's I/Q code for SPS output samples.
module qpsk_modulator #(
  parameter int          SPS     = 4,
  parameter logic [15:0] POS_VAL = 16'h0001,
  parameter logic [15:0] NEG_VAL = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [15:0] I_out,
  output logic [15:0] Q_out,
  output logic        sym_valid,
  output logic        sym_start
);

  typedef enum logic {IDLE, TX} state_t;

  localparam logic [3:0] LAST = 4'(SPS - 1);

  logic       pending;
  logic       pend_bit;
  logic [1:0] fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] head;
  logic       accept;
  logic       push;
  logic       pop;
  state_t     state;
  logic [3:0] hold_cnt;

  // Readiness looks only at the stored count, so a same-cycle pop never frees a slot early.
  assign bit_ready = (count < 2'd2) && !reset;
  assign accept    = bit_valid && bit_ready;
  assign push      = accept && pending;
  assign pop       = (count != 2'd0) && ((state == IDLE) || (hold_cnt == LAST));
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_bit <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
    end else begin
      if (accept) begin
        if (!pending) begin
          pending  <= 1'b1;
          pend_bit <= bit_in;
        end else begin
          pending          <= 1'b0;
          fifo_mem[wr_ptr] <= {bit_in, pend_bit};
          wr_ptr           <= ~wr_ptr;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      I_out     <= '0;
      Q_out     <= '0;
      sym_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      if (pop) begin
        state     <= TX;
        hold_cnt  <= '0;
        I_out     <= head[0] ? POS_VAL : NEG_VAL;
        Q_out     <= head[1] ? POS_VAL : NEG_VAL;
        sym_valid <= 1'b1;
        sym_start <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            hold_cnt  <= '0;
            sym_start <= 1'b0;
          end
          TX: begin
            sym_start <= 1'b0;
            if (hold_cnt == LAST) begin
              state     <= IDLE;
              hold_cnt  <= '0;
              I_out     <= '0;
              Q_out     <= '0;
              sym_valid <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qpsk_modulator.sv
// Directed bench for qpsk_modulator: an SPS=4 instance plus an SPS=2 instance.
module tb_qpsk_modulator;

  logic        clk;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_valid2;
  logic        ready4, ready2;
  logic [15:0] i4, q4, i2, q2;
  logic        v4, s4, v2, s2;

  int n_vec = 0;
  int n_err = 0;
  int n_acc;

  logic [15:0] li [40];
  logic [15:0] lq [40];
  logic        lv [40];
  logic        ls [40];
  logic        lr [40];

  qpsk_modulator #(.SPS(4), .POS_VAL(16'h0001), .NEG_VAL(16'h8000)) dut4 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(ready4), .I_out(i4), .Q_out(q4), .sym_valid(v4), .sym_start(s4)
  );

  qpsk_modulator #(.SPS(2), .POS_VAL(16'h0001), .NEG_VAL(16'h8000)) dut2 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid2),
    .bit_ready(ready2), .I_out(i2), .Q_out(q2), .sym_valid(v2), .sym_start(s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives bits[0..nbits-1] as fast as bit_ready allows, optionally idling gap_len
  // cycles after the gap_at-th accept, and logs outputs seen after each edge.
  task automatic run(input bit sel, input logic [15:0] bits, input int nbits,
                     input int gap_at, input int gap_len, input int ncycles);
    int   idx;
    int   gap;
    logic drive;
    logic rdy;
    idx = 0;
    gap = 0;
    for (int c = 0; c < ncycles; c++) begin
      drive = (idx < nbits) && (gap == 0);
      if (idx < 16) bit_in = bits[idx[3:0]];
      if (sel) bit_valid2 = drive;
      else     bit_valid  = drive;
      rdy = sel ? ready2 : ready4;
      lr[c] = rdy;
      @(posedge clk);
      if (drive && rdy) begin
        idx++;
        if (idx == gap_at) gap = gap_len;
      end else if (gap > 0) begin
        gap--;
      end
      #1;
      li[c] = sel ? i2 : i4;
      lq[c] = sel ? q2 : q4;
      lv[c] = sel ? v2 : v4;
      ls[c] = sel ? s2 : s4;
    end
    bit_valid  = 1'b0;
    bit_valid2 = 1'b0;
    n_acc = idx;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (i4 !== 16'h0000 || q4 !== 16'h0000 || v4 !== 1'b0 || s4 !== 1'b0 || ready4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sps4: got I=%h Q=%h v=%b s=%b rdy=%b, want 0000 0000 0 0 0", i4, q4, v4, s4, ready4);
    end
    n_vec++;
    if (i2 !== 16'h0000 || q2 !== 16'h0000 || v2 !== 1'b0 || s2 !== 1'b0 || ready2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sps2: got I=%h Q=%h v=%b s=%b rdy=%b, want 0000 0000 0 0 0", i2, q2, v2, s2, ready2);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (ready4 !== 1'b1 || ready2 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", ready4, ready2);
    end
  endtask

  task automatic test_single_symbol;
    logic        ev, es;
    logic [15:0] e;
    run(1'b0, 16'h0000, 2, -1, 0, 8);
    for (int j = 0; j < 8; j++) begin
      ev = (j >= 2) && (j <= 5);
      es = (j == 2);
      e  = ev ? 16'h8000 : 16'h0000;
      n_vec++;
      if (li[j] !== e || lq[j] !== e || lv[j] !== ev || ls[j] !== es) begin
        n_err++;
        $display("FAIL single_symbol c%0d: got I=%h Q=%h v=%b s=%b, want I=%h Q=%h v=%b s=%b",
                 j, li[j], lq[j], lv[j], ls[j], e, e, ev, es);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ei_t [4] = '{16'h8000, 16'h0001, 16'h8000, 16'h0001};
    logic [15:0] eq_t [4] = '{16'h8000, 16'h8000, 16'h0001, 16'h0001};
    logic        ev, es;
    logic [15:0] ei, eq;
    run(1'b0, 16'h00E4, 8, -1, 0, 20);
    for (int j = 0; j < 20; j++) begin
      ev = (j >= 2) && (j <= 17);
      es = ev && (((j - 2) % 4) == 0);
      ei = ev ? ei_t[(j - 2) / 4] : 16'h0000;
      eq = ev ? eq_t[(j - 2) / 4] : 16'h0000;
      n_vec++;
      if (li[j] !== ei || lq[j] !== eq || lv[j] !== ev || ls[j] !== es) begin
        n_err++;
        $display("FAIL back_to_back c%0d: got I=%h Q=%h v=%b s=%b, want I=%h Q=%h v=%b s=%b",
                 j, li[j], lq[j], lv[j], ls[j], ei, eq, ev, es);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] ei_t [6] = '{16'h0001, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h8000};
    logic [15:0] eq_t [6] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000, 16'h0001, 16'h8000};
    int nvalid, nstart;
    bit low_seen, rose;
    logic        ev;
    logic [15:0] ei, eq;
    run(1'b0, 16'h0363, 12, -1, 0, 30);
    nvalid = 0; nstart = 0; low_seen = 0; rose = 0;
    for (int j = 0; j < 30; j++) begin
      if (lv[j] === 1'b1) nvalid++;
      if (ls[j] === 1'b1) nstart++;
      if (j < 17 && lr[j] === 1'b0) low_seen = 1;
      if (low_seen && lr[j] === 1'b1) rose = 1;
      ev = (j >= 2) && (j <= 25);
      ei = ev ? ei_t[(j - 2) / 4] : 16'h0000;
      eq = ev ? eq_t[(j - 2) / 4] : 16'h0000;
      n_vec++;
      if (li[j] !== ei || lq[j] !== eq || lv[j] !== ev) begin
        n_err++;
        $display("FAIL backpressure c%0d: got I=%h Q=%h v=%b, want I=%h Q=%h v=%b",
                 j, li[j], lq[j], lv[j], ei, eq, ev);
      end
    end
    n_vec++;
    if (nvalid != 24 || nstart != 6 || n_acc != 12) begin
      n_err++;
      $display("FAIL backpressure_counts: got valid=%0d starts=%0d accepted=%0d, want 24 6 12", nvalid, nstart, n_acc);
    end
    n_vec++;
    if (lr[6] !== 1'b0 || lr[7] !== 1'b1 || !rose) begin
      n_err++;
      $display("FAIL backpressure_ready: got rdy6=%b rdy7=%b rose=%0d, want 0 1 1", lr[6], lr[7], rose);
    end
  endtask

  task automatic test_gap;
    logic        ev, es;
    logic [15:0] e;
    run(1'b0, 16'h0003, 2, 1, 10, 18);
    for (int j = 0; j < 18; j++) begin
      ev = (j >= 12) && (j <= 15);
      es = (j == 12);
      e  = ev ? 16'h0001 : 16'h0000;
      n_vec++;
      if (li[j] !== e || lq[j] !== e || lv[j] !== ev || ls[j] !== es) begin
        n_err++;
        $display("FAIL gap c%0d: got I=%h Q=%h v=%b s=%b, want I=%h Q=%h v=%b s=%b",
                 j, li[j], lq[j], lv[j], ls[j], e, e, ev, es);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic        ev, es;
    logic [15:0] ei, eq;
    run(1'b0, 16'h001C, 6, -1, 0, 4);
    n_vec++;
    if (li[3] !== 16'h8000 || lq[3] !== 16'h8000 || lv[3] !== 1'b1 || ls[3] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_pre: got I=%h Q=%h v=%b s=%b, want 8000 8000 1 0", li[3], lq[3], lv[3], ls[3]);
    end
    reset = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    #1;
    n_vec++;
    if (ready4 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_ready: got %b, want 0", ready4);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (i4 !== 16'h0000 || q4 !== 16'h0000 || v4 !== 1'b0 || s4 !== 1'b0 || ready4 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_out: got I=%h Q=%h v=%b s=%b rdy=%b, want 0000 0000 0 0 0", i4, q4, v4, s4, ready4);
    end
    reset = 1'b0;
    bit_valid = 1'b0;
    #1;
    n_vec++;
    if (ready4 !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_release: got rdy=%b, want 1", ready4);
    end
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (v4 !== 1'b0 || i4 !== 16'h0000) begin
        n_err++;
        $display("FAIL mid_reset_drop c%0d: got v=%b I=%h, want 0 0000", j, v4, i4);
      end
    end
    run(1'b0, 16'h0001, 2, -1, 0, 8);
    for (int j = 0; j < 8; j++) begin
      ev = (j >= 2) && (j <= 5);
      es = (j == 2);
      ei = ev ? 16'h0001 : 16'h0000;
      eq = ev ? 16'h8000 : 16'h0000;
      n_vec++;
      if (li[j] !== ei || lq[j] !== eq || lv[j] !== ev || ls[j] !== es) begin
        n_err++;
        $display("FAIL mid_reset_after c%0d: got I=%h Q=%h v=%b s=%b, want I=%h Q=%h v=%b s=%b",
                 j, li[j], lq[j], lv[j], ls[j], ei, eq, ev, es);
      end
    end
  endtask

  task automatic test_sps2;
    logic [15:0] ei_t [3] = '{16'h0001, 16'h8000, 16'h0001};
    logic [15:0] eq_t [3] = '{16'h8000, 16'h0001, 16'h0001};
    logic        ev, es;
    logic [15:0] ei, eq;
    run(1'b1, 16'h0039, 6, -1, 0, 10);
    for (int j = 0; j < 10; j++) begin
      ev = (j >= 2) && (j <= 7);
      es = ev && ((j % 2) == 0);
      ei = ev ? ei_t[(j - 2) / 2] : 16'h0000;
      eq = ev ? eq_t[(j - 2) / 2] : 16'h0000;
      n_vec++;
      if (li[j] !== ei || lq[j] !== eq || lv[j] !== ev || ls[j] !== es) begin
        n_err++;
        $display("FAIL sps2 c%0d: got I=%h Q=%h v=%b s=%b, want I=%h Q=%h v=%b s=%b",
                 j, li[j], lq[j], lv[j], ls[j], ei, eq, ev, es);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    bit_valid2 = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_symbol();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_mid_reset();
    test_sps2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
